inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch unit: the initiator side of the instruction-memory interface. It owns the program counter, drives InstAddress to the asynchronous-read instruction ROM, and captures the returned word into an instruction register for the decoder. It handles start/halt sequencing, stalls, branch redirect with a one-cycle flush, and a fetch counter. It sits between the instruction ROM and the decode stage of the core.

Parameters:
A, 10, instruction address width; ROM depth is 2**A.
W, 9, instruction word width.
CW, 16, width of the fetch counter.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  begin execution at StartAddr; honoured only in IDLE or HALTED.
StartAddr  in  A  first PC after Start.
InstAddress  out  A  address to the instruction ROM; equals the PC register directly.
InstIn  in  W  ROM data; combinational function of InstAddress, valid in the same cycle.
Stall  in  1  downstream hazard; freezes the PC, InstReg, InstPC, InstValid and FetchCount.
BranchEn  in  1  taken branch for the instruction currently in InstReg.
BranchRel  in  1  1 = relative target, 0 = absolute target.
BranchTarget  in  A  absolute address, or a signed two's-complement offset when BranchRel=1.
HaltReq  in  1  decoder reports that the instruction in InstReg is a halt.
InstReg  out  W  registered instruction word for decode.
InstPC  out  A  address InstReg was fetched from.
InstValid  out  1  InstReg holds a live instruction.
Busy  out  1  state == RUN.
Ack  out  1  high while in HALTED.
FetchCount  out  CW  number of instructions delivered since the last Start; saturates.

Behaviour:
- States: IDLE, RUN, HALTED.
- Reset (synchronous, any state, overrides everything including mid-run): state=IDLE, PC=0, InstReg=0, InstPC=0, InstValid=0, Ack=0, FetchCount=0.
- IDLE or HALTED with Start=1: next cycle state=RUN, PC=StartAddr, InstValid=0, Ack=0, FetchCount=0. Start is ignored in RUN.
- Latency: Start sampled at edge n gives InstAddress=StartAddr after edge n; InstValid=1 with InstReg=rom[StartAddr] after edge n+1.
- RUN actions, in priority order at each edge:
  1. HaltReq & InstValid: state=HALTED, InstValid=0, Ack=1; PC and InstReg hold.
  2. Stall: all registers hold. HaltReq and BranchEn are not acted on; the requester holds them until Stall drops.
  3. BranchEn & InstValid: PC=target, InstValid=0 (one bubble flushes the wrong-path word); FetchCount unchanged.
  4. Otherwise: InstReg=InstIn, InstPC=PC, InstValid=1, PC=PC+1, FetchCount+1.
- HaltReq or BranchEn with InstValid=0 is ignored.
- Branch target: absolute gives target=BranchTarget. Relative gives target=InstPC + BranchTarget mod 2**A, with the offset sign-interpreted as A bits.
- PC arithmetic is modulo 2**A: increment from 2**A-1 wraps to 0, and relative targets wrap the same way.
- FetchCount saturates at 2**CW-1 and does not wrap.
- In IDLE and HALTED, InstAddress holds the last PC value and InstValid=0.
- Busy is combinational from the state register; Ack is registered.

Decomposition:
- Package inst_fetch_pkg holds the fetch_state_t enum (IDLE, RUN, HALTED), localparam defaults A=10 and W=9 shared with the ROM, and the BR_ABS=0 / BR_REL=1 constants.
- One combinational sub-module, fetch_pc_next, computes PC+1 and the branch target from PC, InstPC, BranchRel and BranchTarget. The state machine and registers stay in inst_fetch.

Test Plan:
- Reset, then Start with StartAddr=0x005 -> InstAddress=0x005 next cycle; one cycle later InstValid=1, InstReg=rom[5], InstPC=5; following cycles give PCs 6, 7, 8 and FetchCount 1, 2, 3.
- Stall high for 3 cycles while InstPC=7 -> InstReg, InstPC=7, InstValid and FetchCount hold; fetch resumes at PC 8 when Stall drops.
- BranchEn, BranchRel=1, BranchTarget=0x3FE (-2) while InstPC=0x010 -> one cycle with InstValid=0, then InstPC=0x00E; absolute BranchTarget=0x200 -> InstPC=0x200 after one bubble; FetchCount unchanged during bubbles.
- Start at StartAddr=0x3FE with no branches -> InstPC sequence 0x3FE, 0x3FF, 0x000, 0x001.
- HaltReq with InstValid=1 -> Ack=1, Busy=0, InstValid=0 next cycle; a second Start at 0x020 -> Ack=0 and fetch from 0x020 with FetchCount restarting at 0.
- Reset asserted mid-run at FetchCount=4 -> all outputs return to reset values in the next cycle; HaltReq, BranchEn or Start asserted together with Reset have no effect.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its ROM.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned A_DEF = 10;
  localparam int unsigned W_DEF = 9;

  localparam logic BR_ABS = 1'b0;
  localparam logic BR_REL = 1'b1;

endpackage

// File: rtl/inst_fetch_pc_next.sv
// Next-PC arithmetic: sequential increment and branch target, both modulo 2**A.
module fetch_pc_next
  import inst_fetch_pkg::*;
#(
  parameter int A = A_DEF
) (
  input  logic [A-1:0] pc,
  input  logic [A-1:0] inst_pc,
  input  logic         branch_rel,
  input  logic [A-1:0] branch_target,
  output logic [A-1:0] pc_inc,
  output logic [A-1:0] br_target
);

  // A two's-complement offset added at width A already wraps correctly.
  always_comb begin
    pc_inc = pc + {{(A-1){1'b0}}, 1'b1};
    if (branch_rel == BR_REL) begin
      br_target = inst_pc + branch_target;
    end else begin
      br_target = branch_target;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, drives the async ROM and registers
// the returned word for decode with start/halt, stall and branch handling.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int W  = W_DEF,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [A-1:0]  StartAddr,
  output logic [A-1:0]  InstAddress,
  input  logic [W-1:0]  InstIn,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [A-1:0]  BranchTarget,
  input  logic          HaltReq,
  output logic [W-1:0]  InstReg,
  output logic [A-1:0]  InstPC,
  output logic          InstValid,
  output logic          Busy,
  output logic          Ack,
  output logic [CW-1:0] FetchCount
);

  fetch_state_t  state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [W-1:0]  inst_reg_q, inst_reg_d;
  logic [A-1:0]  inst_pc_q, inst_pc_d;
  logic          inst_valid_q, inst_valid_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] fetch_count_q, fetch_count_d;
  logic [A-1:0]  pc_inc_s, br_target_s;

  fetch_pc_next #(.A(A)) u_pc_next (
    .pc            (pc_q),
    .inst_pc       (inst_pc_q),
    .branch_rel    (BranchRel),
    .branch_target (BranchTarget),
    .pc_inc        (pc_inc_s),
    .br_target     (br_target_s)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      pc_q          <= {A{1'b0}};
      inst_reg_q    <= {W{1'b0}};
      inst_pc_q     <= {A{1'b0}};
      inst_valid_q  <= 1'b0;
      ack_q         <= 1'b0;
      fetch_count_q <= {CW{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_reg_q    <= inst_reg_d;
      inst_pc_q     <= inst_pc_d;
      inst_valid_q  <= inst_valid_d;
      ack_q         <= ack_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // RUN priority: halt, stall, branch, then a normal fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_reg_d    = inst_reg_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    ack_d         = ack_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          state_d       = RUN;
          pc_d          = StartAddr;
          inst_valid_d  = 1'b0;
          ack_d         = 1'b0;
          fetch_count_d = {CW{1'b0}};
        end else begin
          inst_valid_d  = 1'b0;
        end
      end
      RUN: begin
        if (HaltReq && inst_valid_q) begin
          state_d      = HALTED;
          inst_valid_d = 1'b0;
          ack_d        = 1'b1;
        end else if (Stall) begin
          state_d      = RUN;
        end else if (BranchEn && inst_valid_q) begin
          pc_d         = br_target_s;
          inst_valid_d = 1'b0;
        end else begin
          inst_reg_d   = InstIn;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_inc_s;
          if (fetch_count_q != {CW{1'b1}}) begin
            fetch_count_d = fetch_count_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            fetch_count_d = fetch_count_q;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    Busy        = (state_q == RUN);
    Ack         = ack_q;
    InstAddress = pc_q;
    InstReg     = inst_reg_q;
    InstPC      = inst_pc_q;
    InstValid   = inst_valid_q;
    FetchCount  = fetch_count_q;
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed plan plus randomized traffic
// against a behavioural model; a CW=3 copy exercises counter saturation.
module tb_inst_fetch;

  localparam int A   = 10;
  localparam int W   = 9;
  localparam int CW  = 16;
  localparam int M   = 1 << A;
  localparam int CMX = (1 << CW) - 1;
  localparam int SMX = 7;

  logic          clk = 1'b0;
  logic          reset, start, stall, branch_en, branch_rel, halt_req;
  logic [A-1:0]  start_addr, branch_target;
  logic [A-1:0]  inst_address, inst_pc, sat_address, sat_pc;
  logic [W-1:0]  inst_in, inst_reg, sat_in, sat_reg;
  logic          inst_valid, busy, ack, sat_valid, sat_busy, sat_ack;
  logic [CW-1:0] fetch_count;
  logic [2:0]    sat_count;

  int checks = 0;
  int errors = 0;

  function automatic logic [W-1:0] rom_f(input logic [A-1:0] a);
    int v;
    v = int'(a) * 37 + 11;
    return v[W-1:0];
  endfunction

  assign inst_in = rom_f(inst_address);
  assign sat_in  = rom_f(sat_address);

  always #5 clk = ~clk;

  inst_fetch #(.A(A), .W(W), .CW(CW)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .StartAddr(start_addr),
    .InstAddress(inst_address), .InstIn(inst_in), .Stall(stall),
    .BranchEn(branch_en), .BranchRel(branch_rel), .BranchTarget(branch_target),
    .HaltReq(halt_req), .InstReg(inst_reg), .InstPC(inst_pc),
    .InstValid(inst_valid), .Busy(busy), .Ack(ack), .FetchCount(fetch_count)
  );

  inst_fetch #(.A(A), .W(W), .CW(3)) dut_sat (
    .Clk(clk), .Reset(reset), .Start(start), .StartAddr(start_addr),
    .InstAddress(sat_address), .InstIn(sat_in), .Stall(stall),
    .BranchEn(branch_en), .BranchRel(branch_rel), .BranchTarget(branch_target),
    .HaltReq(halt_req), .InstReg(sat_reg), .InstPC(sat_pc),
    .InstValid(sat_valid), .Busy(sat_busy), .Ack(sat_ack), .FetchCount(sat_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0=idle 1=run 2=halted, plain integers.
  int  m_state = 0, m_pc = 0, m_ir = 0, m_ipc = 0, m_cnt = 0;
  bit  m_valid = 0, m_ack = 0, model_ok = 0;

  always @(posedge clk) begin
    int off;
    if (reset) begin
      m_state = 0; m_pc = 0; m_ir = 0; m_ipc = 0; m_cnt = 0;
      m_valid = 0; m_ack = 0; model_ok = 1;
    end else if (model_ok) begin
      if (m_state != 1) begin
        if (start) begin
          m_state = 1; m_pc = int'(start_addr); m_valid = 0; m_ack = 0; m_cnt = 0;
        end
      end else if (halt_req && m_valid) begin
        m_state = 2; m_valid = 0; m_ack = 1;
      end else if (stall) begin
        m_state = 1;
      end else if (branch_en && m_valid) begin
        if (branch_rel) begin
          off  = int'(branch_target);
          if (off >= M / 2) off = off - M;
          m_pc = ((m_ipc + off) % M + M) % M;
        end else begin
          m_pc = int'(branch_target);
        end
        m_valid = 0;
      end else begin
        m_ir    = int'(rom_f(A'(m_pc)));
        m_ipc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 1) % M;
        m_cnt++;
      end
    end
    #1;
    if (model_ok) begin
      chk("m_addr",  32'(inst_address), 32'(m_pc));
      chk("m_ir",    32'(inst_reg),     32'(m_ir));
      chk("m_ipc",   32'(inst_pc),      32'(m_ipc));
      chk("m_valid", 32'(inst_valid),   32'(m_valid));
      chk("m_busy",  32'(busy),         32'(m_state == 1));
      chk("m_ack",   32'(ack),          32'(m_ack));
      chk("m_cnt",   32'(fetch_count),  32'((m_cnt > CMX) ? CMX : m_cnt));
      chk("m_satcnt", 32'(sat_count),   32'((m_cnt > SMX) ? SMX : m_cnt));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int c0;

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_rel = 1'b0;
    halt_req = 1'b0; start_addr = 10'h000; branch_target = 10'h000;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_addr",  32'(inst_address), 32'd0);
    chk("rst_valid", 32'(inst_valid),   32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_cnt",   32'(fetch_count),  32'd0);

    start = 1'b1; start_addr = 10'h005; tick(); start = 1'b0;
    chk("start_addr", 32'(inst_address), 32'h005);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_nv",   32'(inst_valid), 32'd0);
    tick();
    chk("first_valid", 32'(inst_valid), 32'd1);
    chk("first_ir",    32'(inst_reg),   32'd196);
    chk("first_pc",    32'(inst_pc),    32'h005);
    chk("first_cnt",   32'(fetch_count), 32'd1);
    tick(); tick();
    chk("seq_pc", 32'(inst_pc), 32'h007);
    chk("seq_cnt", 32'(fetch_count), 32'd3);

    stall = 1'b1; tick(); tick(); tick();
    chk("stall_pc",  32'(inst_pc), 32'h007);
    chk("stall_cnt", 32'(fetch_count), 32'd3);
    chk("stall_v",   32'(inst_valid), 32'd1);
    stall = 1'b0; tick();
    chk("resume_pc", 32'(inst_pc), 32'h008);

    for (int i = 0; i < 64 && inst_pc != 10'h010; i++) tick();
    chk("reach_pc10", 32'(inst_pc), 32'h010);
    c0 = int'(fetch_count);
    branch_en = 1'b1; branch_rel = 1'b1; branch_target = 10'h3FE; tick();
    branch_en = 1'b0;
    chk("rel_bubble", 32'(inst_valid), 32'd0);
    chk("rel_cnt",    32'(fetch_count), 32'(c0));
    tick();
    chk("rel_pc", 32'(inst_pc), 32'h00E);
    branch_en = 1'b1; branch_rel = 1'b0; branch_target = 10'h200; tick();
    branch_en = 1'b0;
    chk("abs_bubble", 32'(inst_valid), 32'd0);
    tick();
    chk("abs_pc", 32'(inst_pc), 32'h200);

    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("halt_ack",  32'(ack), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_v",    32'(inst_valid), 32'd0);
    start = 1'b1; start_addr = 10'h020; tick(); start = 1'b0;
    chk("restart_ack", 32'(ack), 32'd0);
    chk("restart_cnt", 32'(fetch_count), 32'd0);
    tick();
    chk("restart_pc", 32'(inst_pc), 32'h020);
    tick(); tick(); tick();
    chk("pre_rst_cnt", 32'(fetch_count), 32'd4);

    reset = 1'b1; halt_req = 1'b1; branch_en = 1'b1; start = 1'b1; start_addr = 10'h055;
    tick();
    reset = 1'b0; halt_req = 1'b0; branch_en = 1'b0; start = 1'b0;
    chk("mid_rst_addr", 32'(inst_address), 32'd0);
    chk("mid_rst_ir",   32'(inst_reg), 32'd0);
    chk("mid_rst_v",    32'(inst_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt",  32'(fetch_count), 32'd0);
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    start = 1'b1; start_addr = 10'h3FE; tick(); start = 1'b0;
    tick(); chk("wrap0", 32'(inst_pc), 32'h3FE);
    tick(); chk("wrap1", 32'(inst_pc), 32'h3FF);
    tick(); chk("wrap2", 32'(inst_pc), 32'h000);
    tick(); chk("wrap3", 32'(inst_pc), 32'h001);
    repeat (6) tick();
    chk("cnt10",   32'(fetch_count), 32'd10);
    chk("sat_cnt", 32'(sat_count), 32'd7);

    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      start         = ($urandom_range(0, 24) == 0);
      start_addr    = ($urandom_range(0, 3) == 0) ? A'(M - 1 - int'($urandom_range(0, 3)))
                                                  : A'($urandom);
      stall         = ($urandom_range(0, 4) == 0);
      halt_req      = ($urandom_range(0, 59) == 0);
      branch_en     = ($urandom_range(0, 7) == 0);
      branch_rel    = 1'($urandom);
      branch_target = A'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
